axis_count_gen: RTL and testbench
=================================

AXIS_COUNT_GEN -- requirements
Module: axis_count_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of count_data, cfg_from and cfg_to.
REQ-002 SHALL have parameter STEP_WIDTH, default 8: width of cfg_step.
REQ-003 SHALL have parameter PKT_CNT_WIDTH, default 16: width of pkt_count.
REQ-004 SHALL have port counter_clk, input, 1: the single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start, input, 1: begin a packet; sampled only in IDLE.
REQ-007 SHALL have port stop, input, 1: abort request; sampled only in RUN.
REQ-008 SHALL have port cfg_from, input, DATA_WIDTH: first value of the packet.
REQ-009 SHALL have port cfg_to, input, DATA_WIDTH: terminal bound of the packet.
REQ-010 SHALL have port cfg_step, input, STEP_WIDTH: increment magnitude.
REQ-011 SHALL have port cfg_dir, input, 1: 0 counts up, 1 counts down.
REQ-012 SHALL have port cfg_repeat, input, 1: 1 restarts the packet continuously.
REQ-013 SHALL have port count_data, output, DATA_WIDTH: AXIS TDATA.
REQ-014 SHALL have port count_valid, output, 1: AXIS TVALID.
REQ-015 SHALL have port count_ready, input, 1: AXIS TREADY.
REQ-016 SHALL have port count_last, output, 1: AXIS TLAST.
REQ-017 SHALL have port busy, output, 1: high in RUN.
REQ-018 SHALL have port pkt_count, output, PKT_CNT_WIDTH: number of completed packets; wraps modulo 2^PKT_CNT_WIDTH.

Function
REQ-019 SHALL implement FSM states IDLE and RUN; all outputs registered.
REQ-020 In IDLE with start=1, SHALL capture every cfg_* input, load cur=cfg_from and enter RUN on the next edge; the first beat is valid in the cycle after start.
REQ-021 SHALL ignore changes to cfg_* while in RUN, and SHALL ignore start in RUN.
REQ-022 SHALL treat a captured step of 0 as 1.
REQ-023 In RUN: count_valid=1 and count_data=cur; a beat is transferred only when count_valid&count_ready.
REQ-024 SHALL hold count_data, count_valid and count_last stable while count_valid=1 and count_ready=0; valid is never withdrawn without a transfer.
REQ-025 SHALL mark the beat terminal (count_last=1) when, for up counting, cur>=to or to-cur<step, and for down counting, cur<=to or cur-to<step; comparisons are evaluated in DATA_WIDTH+1 bits so no wrap-around occurs.
REQ-026 On a non-terminal transfer, SHALL update cur to cur+step (up) or cur-step (down) in the next cycle, giving a throughput of 1 beat/cycle with count_ready held high.
REQ-027 On a terminal transfer, SHALL increment pkt_count; with repeat=1, SHALL reload cur=from and stay in RUN (next beat follows without a bubble); with repeat=0, SHALL go to IDLE.
REQ-028 With from beyond to in the counting direction (e.g. up with from>to), SHALL send exactly one beat, the value from with count_last=1.
REQ-029 When stop=1 in RUN, SHALL set a stop-pending flag; the current (or next un-transferred) beat gets count_last=1, and after its transfer SHALL increment pkt_count and go to IDLE regardless of repeat.
REQ-030 When stop and a terminal transfer occur in the same cycle, SHALL go to IDLE once and increment pkt_count once.
REQ-031 In IDLE: count_valid=0, count_last=0, busy=0; count_data holds its last value.

Reset
REQ-032 On reset_n=0 SHALL immediately set state=IDLE, count_valid=0, count_last=0, busy=0, count_data=0, pkt_count=0, and clear stop-pending.
REQ-033 Reset asserted mid-packet SHALL drop the packet without completing it; after reset release, the block waits for a new start.
REQ-034 Reset release SHALL be synchronised to counter_clk.

Verification
REQ-035 Up, from=0, to=9, step=3, repeat=0, ready=1 -> beats 0,3,6,9; last on 9; pkt_count=1; IDLE.
REQ-036 Down, from=10, to=0, step=4 -> beats 10,6,2; last on 2; no underflow.
REQ-037 Random count_ready toggling -> data/valid/last stable while stalled; beat sequence unchanged.
REQ-038 repeat=1, from=5, to=7, step=1 -> 5,6,7(last),5,6,7(last)... back-to-back; pkt_count increments each 7.
REQ-039 stop pulse during beat 3 of 0..100 with ready=0 -> beat 3 presented with last=1; IDLE after its transfer.
REQ-040 Up, from=0xFFFFFFF0, to=0xFFFFFFFF, step=8 -> beats 0xFFFFFFF0, 0xFFFFFFF8(last); reset_n low mid-packet -> valid=0 at once.

Source files
------------

// File: rtl/axis_count_gen.sv
// rtl/axis_count_gen.sv - AXI-Stream counting sequence generator
module axis_count_gen #(
  parameter int DATA_WIDTH    = 32,
  parameter int STEP_WIDTH    = 8,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     counter_clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [DATA_WIDTH-1:0]    cfg_from,
  input  logic [DATA_WIDTH-1:0]    cfg_to,
  input  logic [STEP_WIDTH-1:0]    cfg_step,
  input  logic                     cfg_dir,
  input  logic                     cfg_repeat,
  output logic [DATA_WIDTH-1:0]    count_data,
  output logic                     count_valid,
  input  logic                     count_ready,
  output logic                     count_last,
  output logic                     busy,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count
);

  localparam int EW = DATA_WIDTH + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_n;
  logic [1:0]               rst_sync;
  logic                     rst_sync_n;
  logic [DATA_WIDTH-1:0]    from_r, to_r, data_n, from_n, to_n, next_val;
  logic [STEP_WIDTH-1:0]    step_r, step_n, cfg_step_eff;
  logic                     dir_r, rep_r, dir_n, rep_n;
  logic                     stop_pend, stop_pend_n;
  logic                     valid_n, last_n, busy_n;
  logic [PKT_CNT_WIDTH-1:0] pkt_n;

  // Terminal test done one bit wider than the data so neither difference can wrap.
  function automatic logic is_term(input logic [DATA_WIDTH-1:0] v,
                                   input logic [DATA_WIDTH-1:0] t,
                                   input logic [STEP_WIDTH-1:0] s,
                                   input logic                  d);
    logic [EW-1:0] ve, te, se;
    ve = {1'b0, v};
    te = {1'b0, t};
    se = EW'(s);
    if (!d) is_term = (ve >= te) || ((te - ve) < se);
    else    is_term = (ve <= te) || ((ve - te) < se);
  endfunction

  assign cfg_step_eff = (cfg_step == '0) ? STEP_WIDTH'(1) : cfg_step;
  assign next_val     = dir_r ? (count_data - DATA_WIDTH'(step_r))
                              : (count_data + DATA_WIDTH'(step_r));
  assign rst_sync_n   = rst_sync[1];

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge counter_clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  // State register.
  always_ff @(posedge counter_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= IDLE;
    else             state <= state_n;
  end

  // Next-state and next-output logic; every beat's last flag is precomputed when the beat is loaded.
  always_comb begin
    state_n     = state;
    from_n      = from_r;
    to_n        = to_r;
    step_n      = step_r;
    dir_n       = dir_r;
    rep_n       = rep_r;
    data_n      = count_data;
    valid_n     = count_valid;
    last_n      = count_last;
    busy_n      = busy;
    stop_pend_n = stop_pend;
    pkt_n       = pkt_count;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
        if (start) begin
          from_n      = cfg_from;
          to_n        = cfg_to;
          step_n      = cfg_step_eff;
          dir_n       = cfg_dir;
          rep_n       = cfg_repeat;
          data_n      = cfg_from;
          valid_n     = 1'b1;
          busy_n      = 1'b1;
          last_n      = is_term(cfg_from, cfg_to, cfg_step_eff, cfg_dir);
          stop_pend_n = 1'b0;
          state_n     = RUN;
        end
      end
      RUN: begin
        if (count_ready && count_last) begin
          pkt_n = pkt_count + PKT_CNT_WIDTH'(1);
          if (!rep_r || stop_pend || stop) begin
            state_n     = IDLE;
            valid_n     = 1'b0;
            last_n      = 1'b0;
            busy_n      = 1'b0;
            stop_pend_n = 1'b0;
          end else begin
            data_n = from_r;
            last_n = is_term(from_r, to_r, step_r, dir_r);
          end
        end else if (count_ready) begin
          data_n      = next_val;
          last_n      = is_term(next_val, to_r, step_r, dir_r) | stop_pend | stop;
          stop_pend_n = stop_pend | stop;
        end else begin
          last_n      = count_last | stop;
          stop_pend_n = stop_pend | stop;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge counter_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      from_r      <= '0;
      to_r        <= '0;
      step_r      <= '0;
      dir_r       <= 1'b0;
      rep_r       <= 1'b0;
      count_data  <= '0;
      count_valid <= 1'b0;
      count_last  <= 1'b0;
      busy        <= 1'b0;
      stop_pend   <= 1'b0;
      pkt_count   <= '0;
    end else begin
      from_r      <= from_n;
      to_r        <= to_n;
      step_r      <= step_n;
      dir_r       <= dir_n;
      rep_r       <= rep_n;
      count_data  <= data_n;
      count_valid <= valid_n;
      count_last  <= last_n;
      busy        <= busy_n;
      stop_pend   <= stop_pend_n;
      pkt_count   <= pkt_n;
    end
  end

endmodule

// File: tb/tb_axis_count_gen.sv
// tb/tb_axis_count_gen.sv - self-checking bench for axis_count_gen
module tb_axis_count_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop;
  logic [31:0] cfg_from, cfg_to;
  logic [7:0]  cfg_step;
  logic        cfg_dir, cfg_repeat;
  logic [31:0] count_data;
  logic        count_valid, count_ready, count_last, busy;
  logic [15:0] pkt_count;

  axis_count_gen dut (
    .counter_clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .cfg_from(cfg_from), .cfg_to(cfg_to), .cfg_step(cfg_step),
    .cfg_dir(cfg_dir), .cfg_repeat(cfg_repeat),
    .count_data(count_data), .count_valid(count_valid), .count_ready(count_ready),
    .count_last(count_last), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_pkt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          r_nb;
  logic [31:0] r_first, r_lastv;

  typedef struct {
    logic [31:0] from_v;
    logic [31:0] to_v;
    logic [7:0]  step_v;
    logic        dir_v;
    int          nb;
    logic [31:0] first_v;
    logic [31:0] last_v;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: walk the arithmetic sequence from..to in 64-bit integers until the bound is met.
  function automatic void model(input logic [31:0] f, input logic [31:0] t,
                                input logic [7:0] s, input logic d);
    longint unsigned v, tt, st;
    exp_q.delete();
    v  = longint'(f);
    tt = longint'(t);
    st = (s == 0) ? 1 : longint'(s);
    for (int i = 0; i < 100000; i++) begin
      exp_q.push_back(v[31:0]);
      if (!d) begin
        if (v >= tt || tt - v < st) break;
        v = v + st;
      end else begin
        if (v <= tt || v - tt < st) break;
        v = v - st;
      end
    end
  endfunction

  // One non-repeating packet; called just after a falling edge.
  task automatic run_pkt(input logic [31:0] f, input logic [31:0] t, input logic [7:0] s,
                         input logic d, input bit rnd);
    bit          done, stall;
    logic [31:0] pdata;
    logic        plast, rdy;
    cfg_from = f; cfg_to = t; cfg_step = s; cfg_dir = d; cfg_repeat = 1'b0;
    start = 1'b1; count_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    model(f, t, s, d);
    got_q.delete();
    done = 0; stall = 0; pdata = '0; plast = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (stall) begin
        check("stall_valid", count_valid, 1);
        check("stall_data", count_data, pdata);
        check("stall_last", count_last, plast);
      end
      if (!count_valid) begin
        check("valid_present", count_valid, 1);
        break;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      count_ready = rdy;
      if (rnd) begin
        cfg_from = $urandom; cfg_to = $urandom; cfg_step = 8'($urandom);
        cfg_dir = 1'($urandom); cfg_repeat = 1'($urandom);
        start = 1'($urandom);
      end
      stall = !rdy; pdata = count_data; plast = count_last;
      if (rdy) begin
        got_q.push_back(count_data);
        if (count_last) done = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("pkt_terminated", done, 1);
    check("idle_valid", count_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_last", count_last, 0);
    exp_pkt++;
    check("pkt_count", pkt_count, 64'(exp_pkt & 16'hFFFF));
    check("beat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("beat_value", got_q[i], exp_q[i]);
    r_nb    = got_q.size();
    r_first = (got_q.size() > 0) ? got_q[0] : 32'hDEAD_BEEF;
    r_lastv = (got_q.size() > 0) ? got_q[got_q.size()-1] : 32'hDEAD_BEEF;
  endtask

  vec_t vecs[8];
  logic [31:0] rep_seq[9];

  initial begin
    vecs[0] = '{32'd0,          32'd9,          8'd3,   1'b0, 4, 32'd0,          32'd9};
    vecs[1] = '{32'd10,         32'd0,          8'd4,   1'b1, 3, 32'd10,         32'd2};
    vecs[2] = '{32'hFFFF_FFF0,  32'hFFFF_FFFF,  8'd8,   1'b0, 2, 32'hFFFF_FFF0,  32'hFFFF_FFF8};
    vecs[3] = '{32'd20,         32'd5,          8'd1,   1'b0, 1, 32'd20,         32'd20};
    vecs[4] = '{32'd3,          32'd8,          8'd2,   1'b1, 1, 32'd3,          32'd3};
    vecs[5] = '{32'd4,          32'd7,          8'd0,   1'b0, 4, 32'd4,          32'd7};
    vecs[6] = '{32'd5,          32'd0,          8'd255, 1'b1, 1, 32'd5,          32'd5};
    vecs[7] = '{32'd7,          32'd7,          8'd3,   1'b0, 1, 32'd7,          32'd7};
    rep_seq = '{32'd5, 32'd6, 32'd7, 32'd5, 32'd6, 32'd7, 32'd5, 32'd6, 32'd7};

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; count_ready = 1'b0;
    cfg_from = '0; cfg_to = '0; cfg_step = '0; cfg_dir = 1'b0; cfg_repeat = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", count_valid, 0);
    check("rst_last", count_last, 0);
    check("rst_busy", busy, 0);
    check("rst_data", count_data, 0);
    check("rst_pkt", pkt_count, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", count_valid, 0);

    // Directed vectors, ready held high and with random stalls.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        run_pkt(vecs[i].from_v, vecs[i].to_v, vecs[i].step_v, vecs[i].dir_v, k == 1);
        check("vec_nb", r_nb, vecs[i].nb);
        check("vec_first", r_first, vecs[i].first_v);
        check("vec_lastv", r_lastv, vecs[i].last_v);
        @(negedge clk);
      end
    end

    // Random configurations against the model, with random stalls and cfg/start noise in RUN.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] f, t, span;
      logic [7:0]  s;
      logic        d;
      f = $urandom; d = 1'($urandom); s = 8'($urandom_range(0, 20));
      span = $urandom_range(0, 80);
      t = d ? f - span : f + span;
      if ($urandom_range(0, 3) == 0) t = d ? f + span : f - span;
      run_pkt(f, t, s, d, 1'b1);
    end

    // Repeat mode: back-to-back packets, then stop coinciding with a terminal transfer.
    cfg_from = 32'd5; cfg_to = 32'd7; cfg_step = 8'd1; cfg_dir = 1'b0; cfg_repeat = 1'b1;
    start = 1'b1; count_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("rep_valid", count_valid, 1);
      check("rep_data", count_data, rep_seq[i]);
      check("rep_last", count_last, (i % 3) == 2);
      check("rep_pkt", pkt_count, 64'(exp_pkt + i / 3));
      if (i == 8) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    exp_pkt += 3;
    check("rep_stop_idle", count_valid, 0);
    check("rep_stop_pkt", pkt_count, 64'(exp_pkt));
    repeat (2) @(negedge clk);
    check("rep_stays_idle", count_valid, 0);

    // Stop during beat 3 of 0..100 while stalled.
    cfg_from = 32'd0; cfg_to = 32'd100; cfg_step = 8'd1; cfg_dir = 1'b0; cfg_repeat = 1'b1;
    start = 1'b1; count_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && count_data != 32'd3; i++) @(negedge clk);
    check("stop_at3", count_data, 3);
    check("stop_pre_last", count_last, 0);
    count_ready = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_valid", count_valid, 1);
    check("stop_data", count_data, 3);
    check("stop_last", count_last, 1);
    @(negedge clk);
    check("stop_held", count_data, 3);
    count_ready = 1'b1;
    @(negedge clk);
    exp_pkt++;
    check("stop_idle", count_valid, 0);
    check("stop_busy", busy, 0);
    check("stop_pkt", pkt_count, 64'(exp_pkt));

    // Reset mid-packet drops everything immediately.
    cfg_from = 32'hFFFF_FFF0; cfg_to = 32'hFFFF_FFFF; cfg_step = 8'd1; cfg_repeat = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_valid_before", count_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", count_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", count_data, 0);
    check("mid_rst_pkt", pkt_count, 0);
    exp_pkt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_waits", count_valid, 0);
    run_pkt(32'd0, 32'd9, 8'd3, 1'b0, 1'b0);
    check("after_rst_nb", r_nb, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
